init_delay_pipe: RTL

INIT_DELAY_PIPE -- requirements
Module: init_delay_pipe

---
 rtl/init_delay_pipe.sv | 120 ++++++++++++
 1 files changed

// File: rtl/init_delay_pipe.sv
// init_delay_pipe
//   Enabled data pipeline of DEPTH stages that refuses input for INIT_DELAY
//   cycles after every reset release, giving downstream logic time to
//   settle before the first word arrives. Empty stages (reset, flush,
//   bubbles) always carry the INIT pattern.
//
// Ports
//   clk        single clock, rising edge
//   rstn       synchronous active-low reset
//   en         advance the pipeline by one stage
//   flush      clear every stage back to INIT / invalid
//   in_valid   qualifier for data
//   data       input word
//   ready      registered, high once the start-up wait has elapsed
//   out        last-stage data
//   out_valid  last-stage valid
//   fill       number of stages currently holding valid data
module init_delay_pipe #(
  parameter int              WIDTH      = 4,
  parameter int              DEPTH      = 2,
  parameter logic [WIDTH-1:0] INIT      = '0,
  parameter int              INIT_DELAY = 2
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         en,
  input  logic                         flush,
  input  logic                         in_valid,
  input  logic [WIDTH-1:0]             data,
  output logic                         ready,
  output logic [WIDTH-1:0]             out,
  output logic                         out_valid,
  output logic [$clog2(DEPTH+1)-1:0]   fill
);

  localparam int FILL_W = $clog2(DEPTH + 1);

  // Counter value on which the wait ends. A delay of 0 behaves like a
  // delay of 1: the first edge after release already enters RUN.
  localparam logic [7:0] LAST_COUNT = (INIT_DELAY == 0) ? 8'd0 : 8'(INIT_DELAY - 1);

  typedef enum logic {
    INIT_WAIT,
    RUN
  } stateT;

  stateT            state;
  stateT            stateNext;
  logic [7:0]       delayCount;
  logic [7:0]       delayCountNext;
  logic [WIDTH-1:0] stageData [DEPTH];
  logic [DEPTH-1:0] stageValid;
  logic             accept;

  // State, delay counter and ready register. ready is loaded from the
  // next state so it is high exactly while the FSM sits in RUN, with no
  // path from any input to the port.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= INIT_WAIT;
      delayCount <= 8'd0;
      ready      <= 1'b0;
    end else begin
      state      <= stateNext;
      delayCount <= delayCountNext;
      ready      <= (stateNext == RUN);
    end
  end

  // Next-state logic: count start-up cycles, then stay in RUN until the
  // next reset. flush deliberately has no effect here.
  always_comb begin
    stateNext      = state;
    delayCountNext = delayCount;
    case (state)
      INIT_WAIT: begin
        delayCountNext = delayCount + 8'd1;
        if (delayCount == LAST_COUNT) begin
          stateNext = RUN;
        end
      end
      RUN: begin
        stateNext = RUN;
      end
    endcase
  end

  assign accept = (state == RUN) && en && !flush;

  // Stage registers. Reset and flush both return every stage to INIT with
  // valid cleared; during the start-up wait nothing is ever loaded, so the
  // stages stay at INIT. A bubble (in_valid low) shifts in INIT too.
  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      for (int k = 0; k < DEPTH; k++) begin
        stageData[k] <= INIT;
      end
      stageValid <= '0;
    end else if (accept) begin
      stageData[0]  <= in_valid ? data : INIT;
      stageValid[0] <= in_valid;
      for (int k = 1; k < DEPTH; k++) begin
        stageData[k]  <= stageData[k-1];
        stageValid[k] <= stageValid[k-1];
      end
    end
  end

  assign out       = stageData[DEPTH-1];
  assign out_valid = stageValid[DEPTH-1];

  // Occupancy is simply the number of set valid bits.
  always_comb begin
    fill = '0;
    for (int k = 0; k < DEPTH; k++) begin
      fill = fill + FILL_W'(stageValid[k]);
    end
  end

endmodule
